jt6295_ch_seq: RTL and testbench
================================

// Module: jt6295_ch_seq
// PURPOSE
//  Four-channel nibble sequencer; sits directly upstream of the ADPCM decoder.
//  - Holds start/stop/attenuation state and a nibble pointer per channel.
//  - Fetches ADPCM ROM bytes through a time-multiplexed slot rotation.
//  - Emits one {data, en, att} triplet per cen, slots 0,1,2,3,0,...
//  - This matches the decoder's 4-deep pipeline: each channel's state recirculates every 4 cen.
// PARAMETERS
//  AW  18  ROM byte-address width; the nibble pointer is AW+1 bits.
// PORTS
//  clk        in   1   system clock (single clock domain)
//  rst_n      in   1   asynchronous, active-low reset
//  cen        in   1   clock enable; one channel slot per cen pulse
//  cmd_we     in   1   start request for channel cmd_ch (one clk wide)
//  cmd_ch     in   2   target channel of cmd_we
//  cmd_start  in   AW  first byte address
//  cmd_stop   in   AW  last byte address (inclusive)
//  cmd_att    in   4   attenuation code, passed through unchanged
//  cmd_kill   in   4   one bit per channel: stop playback (one clk wide)
//  rom_addr   out  AW  byte address for the NEXT slot
//  rom_data   in   8   ROM byte at rom_addr
//  rom_ok     in   1   rom_data valid for the current rom_addr
//  slot       out  2   channel index of the current data/en/att
//  data       out  4   ADPCM nibble for the decoder
//  en         out  1   channel active; 0 resets the decoder channel state
//  att        out  4   attenuation for the decoder
//  busy       out  4   per-channel playing flags
//  rom_late   out  1   sticky: rom_ok was low at a consuming cen; cleared only by reset
// BEHAVIOUR
//  Reset: slot=0, data=0, en=0, att=0, busy=0, rom_late=0, rom_addr=0; all pointers 0.
//  Slot rotation: on every cen, slot <= slot+1 (mod 4).
//  - data/en/att are registered and describe the new slot value.
//  - Outputs change only on cen; latency from pointer to output is 1 cen.
//  rom_addr: registered on cen; equals ptr[next slot][AW:1], so ROM has one full cen period.
//  Nibble order: high nibble first (ptr[0]=0 -> rom_data[7:4], ptr[0]=1 -> rom_data[3:0]).
//  Active slot (busy set) at cen:
//  - data = selected nibble, en=1, att = channel att.
//  - ptr <= ptr+1.
//  - If ptr[0]=1 and ptr[AW:1]==stop: busy cleared instead; the next visit emits en=0.
//  Idle slot: data=0, en=0, att = channel att (held).
//  ROM miss (active slot, rom_ok=0 at cen):
//  - data=0, en=1; ptr does not advance; rom_late<=1.
//  - Stop detection is skipped for that visit.
//  Start (cmd_we):
//  - Latched into a per-channel pending register.
//  - Applied at that channel's next slot visit: ptr <= {cmd_start,1'b0}, stop, att loaded, busy<=1.
//  - The first nibble emits one further visit later (rom prefetch).
//  - Start while busy=1 is ignored (no retrigger), as on the original chip.
//  - Second cmd_we to the same channel before it is applied: the last one wins.
//  Kill: clears busy and any pending start at the channel's next visit; kill beats start in the same cycle.
//  Address wrap: ptr increments modulo 2^(AW+1); stop<start plays through the wrap to stop.
//  start==stop: exactly two nibbles play.
//  Reset mid-playback: all channels idle immediately; no output glitch beyond reset values.
// STRUCTURE
//  Shared package jt6295_pkg:
//  - CH_NUM=4, NIB_W=4, ATT_W=4, default AW.
//  - Slot type (2 bits) and per-channel state struct {ptr, stop, att, busy, pend}.
//  One sub-module: jt6295_ch_regs, the 4-entry channel state file.
//  - Read port indexed by next slot.
//  - Write-back on cen.
//  - Command/kill merge logic.
//  Top level holds the slot counter, nibble select, stop compare and output registers.
// TESTING
//  1. Reset, then 8 cen with no commands -> slot cycles 0..3,0..3; en=0, data=0 throughout.
//  2. Start ch1: start=0x00010, stop=0x00011, ROM[0x10]=0x3A, ROM[0x11]=0x5C.
//     -> ch1 emits 3,A,5,C on successive ch1 visits; then en=0 and busy[1]=0.
//  3. Start ch2 while busy[2]=1 (new start=0x200) -> ignored; pointer sequence unchanged.
//  4. cmd_kill[0] and cmd_we ch0 in the same clk -> busy[0] stays 0; next ch0 visit en=0.
//  5. Hold rom_ok=0 for one ch3 visit mid-sample.
//     -> that visit data=0, en=1, rom_late=1; the following visit repeats the held nibble.
//  6. start=0x3FFFF, stop=0x00000 (AW=18).
//     -> nibbles of bytes 0x3FFFF then 0x00000 play; rom_addr wraps; then the channel goes idle.

Source files
------------

// File: rtl/jt6295_pkg.sv
// Shared types and constants for the jt6295 channel sequencer.
package jt6295_pkg;

  localparam int unsigned CH_NUM = 4;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned ATT_W  = 4;
  localparam int unsigned AW_DEF = 18;

  typedef logic [1:0] slot_t;

  // Per-channel playback state. Widths follow AW_DEF, so override AW only
  // together with AW_DEF.
  typedef struct packed {
    logic [AW_DEF:0]   ptr;
    logic [AW_DEF-1:0] stop;
    logic [ATT_W-1:0]  att;
    logic              busy;
    logic              pend;
  } ch_state_t;

  // What a channel does on its slot visit.
  typedef enum logic [1:0] {
    VIS_IDLE,
    VIS_START,
    VIS_PLAY,
    VIS_MISS
  } vis_e;

  // The high nibble plays first.
  function automatic logic [NIB_W-1:0] nib_sel(input logic [7:0] b, input logic lo);
    return lo ? b[3:0] : b[7:4];
  endfunction

endpackage

// File: rtl/jt6295_ch_regs.sv
// Four-entry channel state file with pending start/kill merge.
// The read port presents the visited channel with any pending command applied.
module jt6295_ch_regs
  import jt6295_pkg::*;
#(
  parameter int unsigned AW = AW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cen,
  input  logic [1:0]        vis,
  input  logic              cmd_we,
  input  logic [1:0]        cmd_ch,
  input  logic [AW-1:0]     cmd_start,
  input  logic [AW-1:0]     cmd_stop,
  input  logic [ATT_W-1:0]  cmd_att,
  input  logic [CH_NUM-1:0] cmd_kill,
  input  ch_state_t         wb,
  output ch_state_t         cur,
  output logic              started,
  output logic [AW-1:0]     nxt_addr,
  output logic [CH_NUM-1:0] busy
);

  ch_state_t          st      [CH_NUM];
  logic [AW-1:0]      p_start [CH_NUM];
  logic [AW-1:0]      p_stop  [CH_NUM];
  logic [ATT_W-1:0]   p_att   [CH_NUM];
  logic [CH_NUM-1:0]  kill_p;
  slot_t              nxt;

  assign nxt = vis + 2'd1;

  // Effective state of the visited channel: kill wins over a pending start,
  // and a start only lands on an idle channel.
  always_comb begin
    cur     = st[vis];
    started = 1'b0;
    if (kill_p[vis]) begin
      cur.busy = 1'b0;
    end else if (st[vis].pend && !st[vis].busy) begin
      cur.ptr  = {p_start[vis], 1'b0};
      cur.stop = p_stop[vis];
      cur.att  = p_att[vis];
      cur.busy = 1'b1;
      started  = 1'b1;
    end
    cur.pend = 1'b0;
    nxt_addr = st[nxt].ptr[AW:1];
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      busy[i] = st[i].busy;
    end
  end

  // Write-back of the visited channel, then latching of new commands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < CH_NUM; i++) begin
        st[i]      <= '0;
        p_start[i] <= '0;
        p_stop[i]  <= '0;
        p_att[i]   <= '0;
      end
      kill_p <= '0;
    end else begin
      for (int unsigned i = 0; i < CH_NUM; i++) begin
        if (cen && vis == slot_t'(i)) begin
          st[i]     <= wb;
          kill_p[i] <= 1'b0;
        end
        if (cmd_kill[i]) begin
          kill_p[i]  <= 1'b1;
          st[i].pend <= 1'b0;
        end else if (cmd_we && cmd_ch == slot_t'(i) && !st[i].busy) begin
          st[i].pend <= 1'b1;
          p_start[i] <= cmd_start;
          p_stop[i]  <= cmd_stop;
          p_att[i]   <= cmd_att;
          kill_p[i]  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/jt6295_ch_seq.sv
// Four-channel ADPCM nibble sequencer: slot rotation, ROM prefetch,
// nibble select, stop detection and decoder-facing output registers.
module jt6295_ch_seq
  import jt6295_pkg::*;
#(
  parameter int unsigned AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          cmd_we,
  input  logic [1:0]    cmd_ch,
  input  logic [AW-1:0] cmd_start,
  input  logic [AW-1:0] cmd_stop,
  input  logic [3:0]    cmd_att,
  input  logic [3:0]    cmd_kill,
  output logic [AW-1:0] rom_addr,
  input  logic [7:0]    rom_data,
  input  logic          rom_ok,
  output logic [1:0]    slot,
  output logic [3:0]    data,
  output logic          en,
  output logic [3:0]    att,
  output logic [3:0]    busy,
  output logic          rom_late
);

  slot_t         vis;
  ch_state_t     cur;
  ch_state_t     wb;
  logic          started;
  logic [AW-1:0] nxt_addr;
  vis_e          act;
  logic [3:0]    data_nxt;
  logic          en_nxt;

  assign vis = slot + 2'd1;

  jt6295_ch_regs #(.AW(AW)) u_regs (
    .clk       (clk),
    .rst_n     (rst_n),
    .cen       (cen),
    .vis       (vis),
    .cmd_we    (cmd_we),
    .cmd_ch    (cmd_ch),
    .cmd_start (cmd_start),
    .cmd_stop  (cmd_stop),
    .cmd_att   (cmd_att),
    .cmd_kill  (cmd_kill),
    .wb        (wb),
    .cur       (cur),
    .started   (started),
    .nxt_addr  (nxt_addr),
    .busy      (busy)
  );

  // Classify the visit and compute the emitted nibble and channel write-back.
  always_comb begin
    wb       = cur;
    data_nxt = '0;
    en_nxt   = 1'b0;
    if (started)      act = VIS_START;
    else if (!cur.busy) act = VIS_IDLE;
    else if (!rom_ok) act = VIS_MISS;
    else              act = VIS_PLAY;
    case (act)
      VIS_PLAY: begin
        data_nxt = nib_sel(rom_data, cur.ptr[0]);
        en_nxt   = 1'b1;
        wb.ptr   = cur.ptr + 1'b1;
        if (cur.ptr[0] && cur.ptr[AW:1] == cur.stop) wb.busy = 1'b0;
      end
      VIS_MISS: en_nxt = 1'b1;
      default: ;
    endcase
  end

  // Output registers advance one slot per cen; rom_addr prefetches the slot after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot     <= '0;
      rom_addr <= '0;
      data     <= '0;
      en       <= 1'b0;
      att      <= '0;
      rom_late <= 1'b0;
    end else if (cen) begin
      slot     <= vis;
      rom_addr <= nxt_addr;
      data     <= data_nxt;
      en       <= en_nxt;
      att      <= cur.att;
      if (act == VIS_MISS) rom_late <= 1'b1;
    end
  end

endmodule

// File: tb/tb_jt6295_ch_seq.sv
// Directed and randomized checks of jt6295_ch_seq against a behavioural model.
module tb_jt6295_ch_seq;

  localparam int unsigned AW   = 18;
  localparam int unsigned PMOD = 1 << (AW + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          cen = 1'b0;
  logic          cmd_we = 1'b0;
  logic [1:0]    cmd_ch = '0;
  logic [AW-1:0] cmd_start = '0;
  logic [AW-1:0] cmd_stop = '0;
  logic [3:0]    cmd_att = '0;
  logic [3:0]    cmd_kill = '0;
  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_data;
  logic          rom_ok = 1'b1;
  logic [1:0]    slot;
  logic [3:0]    data;
  logic          en;
  logic [3:0]    att;
  logic [3:0]    busy;
  logic          rom_late;

  logic [7:0] rom_mem [0:(1<<AW)-1];
  assign rom_data = rom_mem[rom_addr];

  jt6295_ch_seq #(.AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .cmd_we(cmd_we), .cmd_ch(cmd_ch),
    .cmd_start(cmd_start), .cmd_stop(cmd_stop), .cmd_att(cmd_att),
    .cmd_kill(cmd_kill), .rom_addr(rom_addr), .rom_data(rom_data),
    .rom_ok(rom_ok), .slot(slot), .data(data), .en(en), .att(att),
    .busy(busy), .rom_late(rom_late)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Reference model: nibble index per channel, inclusive stop byte.
  int unsigned m_ptr[4], m_stop[4], m_att[4];
  int unsigned p_start[4], p_stop[4], p_att[4];
  bit          m_busy[4], m_pend[4], m_kill[4];
  int unsigned m_slot;
  bit          m_late;
  int unsigned e_data, e_en, e_att;

  int         watch_ch = -1;
  logic [3:0] q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_ptr[i] = 0; m_stop[i] = 0; m_att[i] = 0;
      p_start[i] = 0; p_stop[i] = 0; p_att[i] = 0;
      m_busy[i] = 0; m_pend[i] = 0; m_kill[i] = 0;
    end
    m_slot = 0;
    m_late = 0;
  endtask

  task automatic model_visit(input int unsigned c, input bit ok);
    logic [7:0] b;
    e_data = 0;
    e_en   = 0;
    if (m_kill[c]) begin
      m_busy[c] = 0;
      m_kill[c] = 0;
    end else if (m_pend[c] && !m_busy[c]) begin
      m_ptr[c]  = p_start[c] * 2;
      m_stop[c] = p_stop[c];
      m_att[c]  = p_att[c];
      m_busy[c] = 1;
    end else if (m_busy[c]) begin
      e_en = 1;
      if (!ok) begin
        m_late = 1;
      end else begin
        b = rom_mem[m_ptr[c] / 2];
        e_data = (m_ptr[c] % 2 == 1) ? int'(b % 16) : int'(b / 16);
        if (m_ptr[c] % 2 == 1 && m_ptr[c] / 2 == m_stop[c]) m_busy[c] = 0;
        m_ptr[c] = (m_ptr[c] + 1) % PMOD;
      end
    end
    m_pend[c] = 0;
    e_att = m_att[c];
  endtask

  task automatic check_outputs(input int unsigned c);
    logic [3:0] eb;
    for (int i = 0; i < 4; i++) eb[i] = m_busy[i];
    chk("slot", 32'(slot), c);
    chk("data", 32'(data), e_data);
    chk("en", 32'(en), e_en);
    chk("att", 32'(att), e_att);
    chk("busy", 32'(busy), 32'(eb));
    chk("rom_late", 32'(rom_late), 32'(m_late));
    chk("rom_addr", 32'(rom_addr), m_ptr[(c + 1) % 4] / 2);
  endtask

  task automatic cen_step(input bit ok);
    int unsigned c;
    c = (m_slot + 1) % 4;
    model_visit(c, ok);
    cen = 1'b1;
    rom_ok = ok;
    @(posedge clk); #1;
    cen = 1'b0;
    rom_ok = 1'b1;
    m_slot = c;
    check_outputs(c);
    if (watch_ch == int'(c) && en) q.push_back(data);
  endtask

  task automatic do_cmd(input bit we, input int unsigned ch, input int unsigned sa,
                        input int unsigned sp, input int unsigned a, input logic [3:0] kill);
    cmd_we    = we;
    cmd_ch    = ch[1:0];
    cmd_start = sa[AW-1:0];
    cmd_stop  = sp[AW-1:0];
    cmd_att   = a[3:0];
    cmd_kill  = kill;
    @(posedge clk); #1;
    cmd_we   = 1'b0;
    cmd_kill = '0;
    for (int i = 0; i < 4; i++) begin
      if (kill[i]) begin
        m_kill[i] = 1;
        m_pend[i] = 0;
      end else if (we && ch == i && !m_busy[i]) begin
        m_pend[i] = 1;
        p_start[i] = sa; p_stop[i] = sp; p_att[i] = a;
        m_kill[i] = 0;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    chk("rst_slot", 32'(slot), 0);
    chk("rst_data", 32'(data), 0);
    chk("rst_en", 32'(en), 0);
    chk("rst_att", 32'(att), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_late", 32'(rom_late), 0);
    chk("rst_addr", 32'(rom_addr), 0);
    model_reset();
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [3:0] exp_n [4];
    int unsigned ch, sa, sp;
    logic [3:0] kl;

    for (int i = 0; i < (1 << AW); i++) rom_mem[i] = 8'($urandom);
    rom_mem[18'h00010] = 8'h3A;
    rom_mem[18'h00011] = 8'h5C;
    rom_mem[18'h3FFFF] = 8'h96;
    rom_mem[18'h00000] = 8'h1E;
    model_reset();
    #1;
    do_reset();

    // 1: idle rotation
    for (int i = 0; i < 8; i++) cen_step(1'b1);

    // 2: two-byte sample on ch1
    watch_ch = 1;
    q.delete();
    do_cmd(1'b1, 1, 32'h10, 32'h11, 7, 4'b0000);
    for (int i = 0; i < 28; i++) cen_step(1'b1);
    exp_n[0] = 4'h3; exp_n[1] = 4'hA; exp_n[2] = 4'h5; exp_n[3] = 4'hC;
    chk("t2_count", q.size(), 4);
    for (int i = 0; i < 4; i++) if (i < q.size()) chk("t2_nib", 32'(q[i]), 32'(exp_n[i]));
    chk("t2_busy1", 32'(busy[1]), 0);

    // 3: retrigger while busy is ignored
    do_cmd(1'b1, 2, 32'h40, 32'h47, 3, 4'b0000);
    for (int i = 0; i < 12; i++) cen_step(1'b1);
    do_cmd(1'b1, 2, 32'h200, 32'h210, 9, 4'b0000);
    for (int i = 0; i < 8; i++) cen_step(1'b1);
    chk("t3_att2", 32'(m_att[2]), 3);

    // 4: kill and start same cycle on idle ch0
    do_cmd(1'b1, 0, 32'h100, 32'h104, 5, 4'b0001);
    for (int i = 0; i < 8; i++) cen_step(1'b1);
    chk("t4_busy0", 32'(busy[0]), 0);

    // 5: ROM miss on a ch3 visit mid-sample
    do_cmd(1'b1, 3, 32'h80, 32'h83, 2, 4'b0000);
    for (int i = 0; i < 12; i++) cen_step(1'b1);
    while (m_slot != 2) cen_step(1'b1);
    cen_step(1'b0);
    chk("t5_en", 32'(en), 1);
    chk("t5_data", 32'(data), 0);
    chk("t5_late", 32'(rom_late), 1);
    for (int i = 0; i < 8; i++) cen_step(1'b1);

    // 6: address wrap on ch0
    watch_ch = 0;
    q.delete();
    do_cmd(1'b1, 0, 32'h3FFFF, 32'h0, 11, 4'b0000);
    for (int i = 0; i < 28; i++) cen_step(1'b1);
    exp_n[0] = 4'h9; exp_n[1] = 4'h6; exp_n[2] = 4'h1; exp_n[3] = 4'hE;
    chk("t6_count", q.size(), 4);
    for (int i = 0; i < 4; i++) if (i < q.size()) chk("t6_nib", 32'(q[i]), 32'(exp_n[i]));
    chk("t6_busy0", 32'(busy[0]), 0);
    watch_ch = -1;

    // Reset mid-playback
    do_cmd(1'b1, 1, 32'h500, 32'h520, 4, 4'b0000);
    for (int i = 0; i < 10; i++) cen_step(1'b1);
    do_reset();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        ch = $urandom_range(0, 3);
        sa = $urandom_range(0, (1 << AW) - 1);
        sp = (sa + $urandom_range(0, 5)) % (1 << AW);
        kl = ($urandom_range(0, 7) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0000;
        do_cmd($urandom_range(0, 3) != 0, ch, sa, sp, $urandom_range(0, 15), kl);
      end
      cen_step($urandom_range(0, 9) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
